wb0_master: RTL and testbench
=============================

WB0_MASTER -- requirements
Module: wb0_master

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h0000_0000: byte address of the first burst; must be 16-byte aligned.
REQ-002 SHALL have parameter NUM_BURSTS, default 16: number of 4-beat bursts per phase, range 1..65535.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port adr, output, 32: Wishbone byte address.
REQ-006 SHALL have port bte, output, 2: burst type extension.
REQ-007 SHALL have port cti, output, 3: cycle type identifier.
REQ-008 SHALL have port cyc, output, 1: bus cycle.
REQ-009 SHALL have port stb, output, 1: strobe.
REQ-010 SHALL have port we, output, 1: write enable.
REQ-011 SHALL have port sel, output, 4: byte selects.
REQ-012 SHALL have port dat, output, 32: write data.
REQ-013 SHALL have port ack, input, 1: slave acknowledge.
REQ-014 SHALL have port dat_i, input, 32: read data.
REQ-015 SHALL have port done, output, 1: sequence finished.
REQ-016 SHALL have port ok, output, 1: pass flag, valid when done=1.

Function
REQ-017 SHALL implement the states IDLE, WR, GAP_WR, RD, GAP_RD and DONE.
REQ-018 IDLE SHALL go to WR on the first clock edge after reset deasserts.
REQ-019 In WR/RD, cyc=stb=1, sel=4'hF, bte=2'b01 (4-beat wrap).
REQ-020 Within a burst, cti SHALL be 3'b010 on beats 0-2 and 3'b111 on beat 3.
REQ-021 Beat address SHALL be BASE_ADR + burst*16 + beat*4; the burst and beat counters are 16-bit and 2-bit.
REQ-022 The master SHALL hold all bus outputs stable while ack=0.
REQ-023 The beat SHALL advance on the clock edge where cyc&stb&ack=1, with zero added wait states from the master.
REQ-024 ack SHALL be ignored while stb=0.
REQ-025 WR SHALL drive we=1 and dat=adr of the current beat.
REQ-026 RD SHALL drive we=0 and dat=0.
REQ-027 After the beat-3 ack, the master SHALL enter GAP_* for exactly one cycle with cyc=stb=0, then start the next burst.
REQ-028 After burst NUM_BURSTS-1, the master SHALL go WR->GAP_WR->RD (burst counter cleared) and RD->GAP_RD->DONE.
REQ-029 In RD, on each acked beat, dat_i SHALL be compared with the beat address; a mismatch sets a sticky error flag.
REQ-030 DONE SHALL be terminal: cyc=stb=we=0, done=1, ok=~error; only reset leaves DONE.
REQ-031 All outputs SHALL be registered (no combinational path from ack/dat_i to outputs).

Reset
REQ-032 reset=0 SHALL immediately force state IDLE, all counters 0, error=0, and every output 0 (adr, bte, cti, cyc, stb, we, sel, dat, done, ok).
REQ-033 Reset mid-burst SHALL abort the burst without completion; after release the sequence restarts from burst 0 of WR.

Configuration
REQ-034 Macro WB0_READ_CHECK_EN defined: WR and RD phases and compare SHALL run as specified.
REQ-035 Macro WB0_READ_CHECK_EN undefined: GAP_WR SHALL go directly to DONE, RD is never entered, and ok=1 at done.

Verification
REQ-036 Zero-wait slave echoing memory, NUM_BURSTS=2, BASE_ADR=0 -> writes 0x0,0x4,0x8,0xC,0x10..0x1C with dat=adr and cti 010,010,010,111, then identical reads, done=1, ok=1.
REQ-037 Slave inserting 3 wait cycles per beat -> outputs stable during waits, same address order, ok=1.
REQ-038 Slave returning 32'hDEAD_BEEF for read address 0x14 -> done=1, ok=0.
REQ-039 Reset asserted during beat 2 of burst 1 -> all outputs 0 same cycle; after release the first request is adr=BASE_ADR, we=1.
REQ-040 WB0_READ_CHECK_EN undefined, NUM_BURSTS=1 -> 4 write beats, we never 0 while cyc=1, done=1, ok=1.
REQ-041 Check exactly one idle cycle (cyc=0) between consecutive bursts in every scenario.

Source files
------------

// File: rtl/wb0_master.sv
// Wishbone B4 burst test master: writes NUM_BURSTS 4-beat wrap bursts with dat=adr, then reads them back and
// compares. Outputs are registered; the beat holds until ack. WB0_READ_CHECK_EN enables the read/compare phase.
module wb0_master #(
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter int          NUM_BURSTS = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] adr,
    output logic [1:0]  bte,
    output logic [2:0]  cti,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [3:0]  sel,
    output logic [31:0] dat,
    input  logic        ack,
    input  logic [31:0] dat_i,
    output logic        done,
    output logic        ok
);

    typedef enum logic [2:0] {IDLE, WR, GAP_WR, RD, GAP_RD, DONE} state_t;

    localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);

    state_t      state, state_nxt;
    logic [15:0] burst, burst_nxt;
    logic [1:0]  beat, beat_nxt;
    logic        error, error_nxt;
    logic        beat_acc;

    logic [31:0] adr_nxt, dat_nxt;
    logic [1:0]  bte_nxt;
    logic [2:0]  cti_nxt;
    logic        cyc_nxt, stb_nxt, we_nxt, done_nxt, ok_nxt;
    logic [3:0]  sel_nxt;

    always_comb begin
        state_nxt = state;
        burst_nxt = burst;
        beat_nxt  = beat;
        error_nxt = error;
        beat_acc  = cyc & stb & ack;

        case (state)
            IDLE: begin
                state_nxt = WR;
                burst_nxt = 16'h0;
                beat_nxt  = 2'd0;
            end
            WR: begin
                if (beat_acc) begin
                    if (beat == 2'd3) begin
                        beat_nxt  = 2'd0;
                        state_nxt = GAP_WR;
                    end else begin
                        beat_nxt = beat + 2'd1;
                    end
                end
            end
            GAP_WR: begin
                if (burst == LAST_BURST) begin
                    burst_nxt = 16'h0;
`ifdef WB0_READ_CHECK_EN
                    state_nxt = RD;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    burst_nxt = burst + 16'd1;
                    state_nxt = WR;
                end
            end
            RD: begin
                if (beat_acc) begin
                    // adr is the registered address of the beat being acked
                    if (dat_i != adr) error_nxt = 1'b1;
                    if (beat == 2'd3) begin
                        beat_nxt  = 2'd0;
                        state_nxt = GAP_RD;
                    end else begin
                        beat_nxt = beat + 2'd1;
                    end
                end
            end
            GAP_RD: begin
                if (burst == LAST_BURST) begin
                    state_nxt = DONE;
                end else begin
                    burst_nxt = burst + 16'd1;
                    state_nxt = RD;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase

        // Bus outputs are decoded from the next state so they register in step with it.
        adr_nxt  = 32'h0;
        dat_nxt  = 32'h0;
        bte_nxt  = 2'b00;
        cti_nxt  = 3'b000;
        cyc_nxt  = 1'b0;
        stb_nxt  = 1'b0;
        we_nxt   = 1'b0;
        sel_nxt  = 4'h0;
        done_nxt = 1'b0;
        ok_nxt   = 1'b0;

        if (state_nxt == WR || state_nxt == RD) begin
            adr_nxt = BASE_ADR + {12'h0, burst_nxt, 4'h0} + {28'h0, beat_nxt, 2'b00};
            cyc_nxt = 1'b1;
            stb_nxt = 1'b1;
            sel_nxt = 4'hF;
            bte_nxt = 2'b01;
            cti_nxt = (beat_nxt == 2'd3) ? 3'b111 : 3'b010;
            if (state_nxt == WR) begin
                we_nxt  = 1'b1;
                dat_nxt = adr_nxt;
            end
        end

        if (state_nxt == DONE) begin
            done_nxt = 1'b1;
`ifdef WB0_READ_CHECK_EN
            ok_nxt   = ~error_nxt;
`else
            ok_nxt   = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            burst <= 16'h0;
            beat  <= 2'd0;
            error <= 1'b0;
            adr   <= 32'h0;
            dat   <= 32'h0;
            bte   <= 2'b00;
            cti   <= 3'b000;
            cyc   <= 1'b0;
            stb   <= 1'b0;
            we    <= 1'b0;
            sel   <= 4'h0;
            done  <= 1'b0;
            ok    <= 1'b0;
        end else begin
            state <= state_nxt;
            burst <= burst_nxt;
            beat  <= beat_nxt;
            error <= error_nxt;
            adr   <= adr_nxt;
            dat   <= dat_nxt;
            bte   <= bte_nxt;
            cti   <= cti_nxt;
            cyc   <= cyc_nxt;
            stb   <= stb_nxt;
            we    <= we_nxt;
            sel   <= sel_nxt;
            done  <= done_nxt;
            ok    <= ok_nxt;
        end
    end

endmodule

// File: tb/tb_wb0_master.sv
// Bench for wb0_master: memory slave with configurable waits, stray acks and one corrupted read address.
module tb_wb0_master;

    localparam logic [31:0] BASE = 32'h0000_0040;
    localparam int          NB   = 2;
`ifdef WB0_READ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] adr, dat, dat_i;
    logic [1:0]  bte;
    logic [2:0]  cti;
    logic        cyc, stb, we, ack, done, ok;
    logic [3:0]  sel;

    wb0_master #(.BASE_ADR(BASE), .NUM_BURSTS(NB)) dut (
        .clk(clk), .reset(reset), .adr(adr), .bte(bte), .cti(cti), .cyc(cyc), .stb(stb),
        .we(we), .sel(sel), .dat(dat), .ack(ack), .dat_i(dat_i), .done(done), .ok(ok)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [2:0]  cti;
    } beat_t;

    typedef struct {
        int          waits;
        logic [31:0] bad;
        bit          stray;
        bit          exp_ok;
    } vec_t;

    beat_t       exp_q[$];
    logic [31:0] mem [0:255];
    int          n_vec = 0;
    int          n_err = 0;

    int          waits = 0;
    logic [31:0] bad_adr = 32'hFFFF_FFFF;
    bit          stray = 1'b0;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Slave, scoreboard pop and bus-protocol monitor all run on the falling edge.
    int          wcnt = 0;
    bit          prev_wait = 1'b0;
    logic [95:0] prev_bus = '0;
    bit          prev_cyc = 1'b0;
    bit          seen_burst = 1'b0;
    int          idle_cnt = 0;

    always @(negedge clk) begin
        logic [95:0] bus;
        beat_t       e;
        bus = {20'h0, adr, bte, cti, cyc, stb, we, sel, dat};

        if (prev_wait && reset) check("hold_during_wait", bus, prev_bus);

        if (cyc && stb) begin
            if (wcnt >= waits) begin
                ack   = 1'b1;
                dat_i = (adr == bad_adr) ? 32'hDEAD_BEEF : mem[adr[9:2]];
                wcnt  = 0;
            end else begin
                ack   = 1'b0;
                dat_i = 32'h0;
                wcnt++;
            end
        end else begin
            ack   = stray;
            dat_i = 32'h0;
            wcnt  = 0;
        end

        if (cyc && stb && ack) begin
            if (we) mem[adr[9:2]] = dat;
            check("bus_static", {90'h0, sel, bte}, {90'h0, 4'hF, 2'b01});
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {64'h0, adr}, 96'h0);
            end else begin
                e = exp_q.pop_front();
                check("beat", {28'h0, adr, we, dat, cti}, {28'h0, e});
            end
        end

        if (!reset) begin
            seen_burst = 1'b0;
            idle_cnt   = 0;
        end else if (cyc) begin
            if (!prev_cyc && seen_burst) check("gap_len", 96'(idle_cnt), 96'd1);
            seen_burst = 1'b1;
            idle_cnt   = 0;
        end else begin
            idle_cnt++;
        end

        prev_cyc  = cyc;
        prev_wait = reset && cyc && stb && !ack;
        prev_bus  = bus;
    end

    task automatic push_expected();
        exp_q.delete();
        for (int p = 0; p < (CHK ? 2 : 1); p++)
            for (int b = 0; b < NB; b++)
                for (int k = 0; k < 4; k++) begin
                    beat_t e;
                    e.adr = BASE + 32'(b * 16) + 32'(k * 4);
                    e.we  = (p == 0);
                    e.dat = (p == 0) ? e.adr : 32'h0;
                    e.cti = (k == 3) ? 3'b111 : 3'b010;
                    exp_q.push_back(e);
                end
    endtask

    task automatic check_reset_outputs(input string nm);
        check(nm, {20'h0, adr, bte, cti, cyc, stb, we, sel, dat, done, ok}, 96'h0);
    endtask

    task automatic wait_done(output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                hit = 1'b1;
                return;
            end
        end
    endtask

    task automatic start_run(input int w, input logic [31:0] bad, input bit st);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        waits   = w;
        bad_adr = bad;
        stray   = st;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        push_expected();
        check_reset_outputs("reset_state");
        reset = 1'b1;
    endtask

    vec_t tbl[5];

    initial begin
        bit hit;

        tbl[0] = '{0, 32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[1] = '{3, 32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[2] = '{0, BASE + 32'h14, 1'b0, !CHK};
        tbl[3] = '{1, BASE + 32'h1C, 1'b1, !CHK};
        tbl[4] = '{2, BASE + 32'h80, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check_reset_outputs("power_on_reset");

        for (int t = 0; t < 5; t++) begin
            start_run(tbl[t].waits, tbl[t].bad, tbl[t].stray);
            wait_done(hit);
            check("done_reached", 96'(hit), 96'd1);
            check("ok_at_done", {94'h0, done, ok}, {94'h0, 1'b1, tbl[t].exp_ok});
            check("all_beats_seen", 96'(exp_q.size()), 96'd0);
            repeat (4) @(negedge clk);
            check("done_terminal", {93'h0, done, cyc, stb}, {93'h0, 3'b100});
        end

        // Abort in beat 2 of burst 1 of the write phase, then restart from the top.
        start_run(3, 32'hFFFF_FFFF, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (cyc && we && adr == BASE + 32'h18) hit = 1'b1;
        end
        check("reached_mid_burst", 96'(hit), 96'd1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_reset_clears");
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_held");
        push_expected();
        reset = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (cyc) hit = 1'b1;
        end
        check("restart_first_req", {63'h0, hit, adr, we}, {63'h0, 1'b1, BASE, 1'b1});
        wait_done(hit);
        check("restart_done", {94'h0, hit, ok}, {94'h0, 2'b11});
        check("restart_all_beats", 96'(exp_q.size()), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
